uart_rx_os: RTL and testbench

Oversampling UART receiver that succeeds the single-rate receiver in the serial front end. Frame format is parametrised: 5–9 data bits, optional even/odd parity, 1 or 2 stop bits. Baud rate is runtime-programmable through a divisor, with majority-vote mid-bit sampling. Received characters, each tagged with its error flags, go into an on-chip FIFO that drains over a valid/ready stream to the command parser.

---
 rtl/uart_rx_os.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority-vote bit decisions,
// runtime baud divisor, break detection and a first-word-fall-through
// character FIFO drained over a valid/ready stream.
module uart_rx_os #(
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            uart_rxd,
    input  logic                            uart_rx_en,
    input  logic [DIV_WIDTH-1:0]            baud_div,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [PAYLOAD_BITS-1:0]         m_data,
    output logic                            m_frame_err,
    output logic                            m_parity_err,
    output logic                            m_break,
    output logic                            overrun,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            rx_busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(PAYLOAD_BITS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = PAYLOAD_BITS + 3;

    localparam logic [SW-1:0] VOTE0     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] VOTE1     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] VOTE2     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] LAST_SAMP = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(PAYLOAD_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY != 0);
    localparam logic          ODD_PAR   = (PARITY == 2);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_BRKWAIT = 3'd5
    } state_t;

    state_t                     state, state_next;
    logic                       sync1, line;
    logic [DIV_WIDTH-1:0]       div_reg, div_cnt;
    logic [SW-1:0]              samp_cnt;
    logic                       tick, cnt_clr, decide;
    logic                       vote0, vote1, maj;
    logic [PAYLOAD_BITS-1:0]    shift;
    logic [BW-1:0]              bit_cnt;
    logic                       stop_cnt;
    logic                       par_bit, ferr, ferr_now, perr, brk;
    logic                       push_req;
    logic [EW-1:0]              push_entry;

    logic [EW-1:0]              mem [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [LW-1:0]              level;
    logic                       full, pop, push_ok;
    logic [EW-1:0]              head;

    // Two-out-of-three vote over the mid-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Line synchroniser; resets to the idle (high) level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            line  <= sync1;
        end
    end

    // Baud divisor is only taken while idle so a frame never changes rate.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            div_reg <= '0;
        else if (state == S_IDLE)
            div_reg <= baud_div;
    end

    // Counters restart on start detection (all of IDLE), on entry to BRKWAIT
    // and while the line is still low in BRKWAIT, so a bit time is measured
    // from the rising edge.
    assign cnt_clr = (state == S_IDLE)
                   || (state == S_BRKWAIT && !line)
                   || (state != S_BRKWAIT && state_next == S_BRKWAIT);
    assign tick    = (state != S_IDLE) && (div_cnt == div_reg);
    assign decide  = tick && (samp_cnt == VOTE2);
    assign maj     = majority3(vote0, vote1, line);

    // Oversample tick divider and per-bit sample counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else if (cnt_clr) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            samp_cnt <= (samp_cnt == LAST_SAMP) ? '0 : samp_cnt + 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    // First two votes are held; the third is the live line at the decision tick.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vote0 <= 1'b1;
            vote1 <= 1'b1;
        end else if (tick) begin
            if (samp_cnt == VOTE0) vote0 <= line;
            if (samp_cnt == VOTE1) vote1 <= line;
        end
    end

    assign ferr_now = ferr | ~maj;
    assign perr     = HAS_PAR && ((^shift ^ par_bit) != ODD_PAR);
    assign brk      = ferr_now && (shift == '0) && !par_bit;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // FSM next-state logic; a dropped enable always returns to IDLE.
    always_comb begin
        state_next = state;
        if (!uart_rx_en) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (!line) state_next = S_START;
                S_START:   if (decide) state_next = maj ? S_IDLE : S_DATA;
                S_DATA:    if (decide && bit_cnt == LAST_BIT)
                               state_next = HAS_PAR ? S_PARITY : S_STOP;
                S_PARITY:  if (decide) state_next = S_STOP;
                S_STOP:    if (decide && stop_cnt == LAST_STOP)
                               state_next = brk ? S_BRKWAIT : S_IDLE;
                S_BRKWAIT: if (tick && samp_cnt == LAST_SAMP && line)
                               state_next = S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        rx_busy = (state != S_IDLE);
    end

    // Frame assembly: data shift, parity capture, stop checking and push request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par_bit    <= 1'b0;
            ferr       <= 1'b0;
            push_req   <= 1'b0;
            push_entry <= '0;
        end else begin
            push_req <= 1'b0;
            if (state == S_IDLE) begin
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                par_bit  <= 1'b0;
                ferr     <= 1'b0;
            end else if (decide && uart_rx_en) begin
                case (state)
                    S_DATA: begin
                        shift   <= {maj, shift[PAYLOAD_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    S_PARITY: par_bit <= maj;
                    S_STOP: begin
                        if (stop_cnt == LAST_STOP) begin
                            push_req   <= 1'b1;
                            push_entry <= {brk, perr, ferr_now, shift};
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                            ferr     <= ferr_now;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign full    = (level == FULL_LVL);
    assign m_valid = (level != '0);
    assign pop     = m_valid && m_ready;
    assign push_ok = push_req && (!full || pop);
    assign overrun = push_req && full && !pop;
    assign head    = mem[rd_ptr];
    assign {m_break, m_parity_err, m_frame_err, m_data} = m_valid ? head : '0;
    assign fifo_level = level;

    // FIFO storage; outputs are gated by m_valid so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_entry;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os. Instance u_a is 8N1 with a
// 4-deep FIFO; instance u_b is 8E2 with an 8-deep FIFO. Entries popped from
// either instance are collected and compared against hand-computed values
// encoded as {break, parity_err, frame_err, data}.
module tb_uart_rx_os;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rxd_a, rxd_b, en_a, en_b, rdy_a, rdy_b;
    logic [15:0] div_a, div_b;

    logic        val_a, ferr_a, perr_a, brk_a, ovr_a, busy_a;
    logic [7:0]  data_a;
    logic [2:0]  lvl_a;
    logic        val_b, ferr_b, perr_b, brk_b, ovr_b, busy_b;
    logic [7:0]  data_b;
    logic [3:0]  lvl_b;

    int          vectors = 0;
    int          miscompares = 0;
    int          ovr_cnt_a = 0;
    int          ovr_cnt_b = 0;
    logic [10:0] q_a[$];
    logic [10:0] q_b[$];

    always #5 clk = ~clk;

    uart_rx_os #(.PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16),
                 .DIV_WIDTH(16), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd_a), .uart_rx_en(en_a),
        .baud_div(div_a), .m_valid(val_a), .m_ready(rdy_a), .m_data(data_a),
        .m_frame_err(ferr_a), .m_parity_err(perr_a), .m_break(brk_a),
        .overrun(ovr_a), .fifo_level(lvl_a), .rx_busy(busy_a));

    uart_rx_os #(.PAYLOAD_BITS(8), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(16),
                 .DIV_WIDTH(16), .FIFO_DEPTH(8)) u_b (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd_b), .uart_rx_en(en_b),
        .baud_div(div_b), .m_valid(val_b), .m_ready(rdy_b), .m_data(data_b),
        .m_frame_err(ferr_b), .m_parity_err(perr_b), .m_break(brk_b),
        .overrun(ovr_b), .fifo_level(lvl_b), .rx_busy(busy_b));

    // Collect popped entries and count overrun pulses away from the active edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (val_a && rdy_a) q_a.push_back({brk_a, perr_a, ferr_a, data_a});
            if (val_b && rdy_b) q_b.push_back({brk_b, perr_b, ferr_b, data_b});
            if (ovr_a) ovr_cnt_a++;
            if (ovr_b) ovr_cnt_b++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else     rxd_a = v;
    endtask

    task automatic send_bits(input bit sel, input logic [15:0] bits, input int n, input int cyc);
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i]);
            cycles(cyc);
        end
        drive(sel, 1'b1);
    endtask

    task automatic send_a(input logic [7:0] d, input int cyc);
        send_bits(1'b0, {6'b0, 1'b1, d, 1'b0}, 10, cyc);
        cycles(cyc);
    endtask

    task automatic send_b(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        send_bits(1'b1, {4'b0, s2, s1, p, d, 1'b0}, 12, 32);
        cycles(32);
    endtask

    task automatic expect_a(input string tag, input logic [10:0] exp);
        if (q_a.size() == 0) check_value({tag, "_present"}, 32'(q_a.size()), 32'd1);
        else                 check_value(tag, 32'(q_a.pop_front()), 32'(exp));
    endtask

    task automatic expect_b(input string tag, input logic [10:0] exp);
        if (q_b.size() == 0) check_value({tag, "_present"}, 32'(q_b.size()), 32'd1);
        else                 check_value(tag, 32'(q_b.pop_front()), 32'(exp));
    endtask

    initial begin
        resetn = 1'b0;
        rxd_a = 1'b1; rxd_b = 1'b1;
        en_a = 1'b1;  en_b = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b1;
        div_a = 16'd1; div_b = 16'd1;
        cycles(3);

        // Reset state
        check_value("rst_valid", 32'(val_a), 32'd0);
        check_value("rst_data", 32'(data_a), 32'd0);
        check_value("rst_flags", 32'({brk_a, perr_a, ferr_a}), 32'd0);
        check_value("rst_overrun", 32'(ovr_a), 32'd0);
        check_value("rst_level", 32'(lvl_a), 32'd0);
        check_value("rst_busy", 32'(busy_a), 32'd0);
        check_value("rst_busy_b", 32'(busy_b), 32'd0);
        resetn = 1'b1;
        cycles(5);

        // 8N1 at 32 cycles/bit, consumer always ready
        rdy_a = 1'b1;
        send_a(8'hA5, 32);
        send_a(8'h3C, 32);
        cycles(64);
        expect_a("8n1_first", 11'h0A5);
        expect_a("8n1_second", 11'h03C);
        check_value("8n1_ovr", 32'(ovr_cnt_a), 32'd0);

        // Fill the 4-deep FIFO with five frames while stalled
        rdy_a = 1'b0;
        for (int d = 1; d <= 5; d++) send_a(8'(d), 32);
        cycles(64);
        check_value("full_level", 32'(lvl_a), 32'd4);
        check_value("full_ovr_once", 32'(ovr_cnt_a), 32'd1);
        check_value("full_head_held", 32'(data_a), 32'h01);
        check_value("full_valid", 32'(val_a), 32'd1);
        rdy_a = 1'b1;
        cycles(10);
        for (int d = 1; d <= 4; d++) expect_a($sformatf("drain_%0d", d), 11'(d));
        check_value("drain_lost5", 32'(q_a.size()), 32'd0);
        check_value("drain_level", 32'(lvl_a), 32'd0);

        // Short glitch: false start
        drive(1'b0, 1'b0);
        cycles(5);
        drive(1'b0, 1'b1);
        cycles(3);
        check_value("glitch_busy", 32'(busy_a), 32'd1);
        cycles(60);
        check_value("glitch_idle", 32'(busy_a), 32'd0);
        check_value("glitch_noentry", 32'(q_a.size()), 32'd0);

        // Divisor change to 3: 64 cycles/bit
        div_a = 16'd3;
        send_a(8'h96, 64);
        cycles(128);
        expect_a("div3_frame", 11'h096);
        div_a = 16'd1;
        cycles(10);

        // Reset in the middle of data bit 4 with one entry pending
        rdy_a = 1'b0;
        send_a(8'h11, 32);
        cycles(32);
        check_value("pre_rst_level", 32'(lvl_a), 32'd1);
        drive(1'b0, 1'b0);
        cycles(5 * 32 + 16);
        check_value("pre_rst_busy", 32'(busy_a), 32'd1);
        resetn = 1'b0;
        #2;
        check_value("midrst_level", 32'(lvl_a), 32'd0);
        check_value("midrst_valid", 32'(val_a), 32'd0);
        check_value("midrst_busy", 32'(busy_a), 32'd0);
        check_value("midrst_data", 32'(data_a), 32'd0);
        drive(1'b0, 1'b1);
        cycles(3);
        resetn = 1'b1;
        cycles(5);
        rdy_a = 1'b1;
        send_a(8'h5A, 32);
        cycles(64);
        expect_a("post_rst_frame", 11'h05A);
        check_value("post_rst_only", 32'(q_a.size()), 32'd0);

        // Enable dropped during data bit 1
        drive(1'b0, 1'b0);
        cycles(3 * 32);
        en_a = 1'b0;
        cycles(2);
        check_value("en_drop_busy", 32'(busy_a), 32'd0);
        drive(1'b0, 1'b1);
        cycles(7 * 32);
        en_a = 1'b1;
        cycles(64);
        check_value("en_drop_noentry", 32'(q_a.size()), 32'd0);
        check_value("en_drop_level", 32'(lvl_a), 32'd0);

        // 8E2: wrong then correct parity on 0x3C
        send_b(8'h3C, 1'b1, 1'b1, 1'b1);
        cycles(64);
        expect_b("par_bad", 11'h23C);
        send_b(8'h3C, 1'b0, 1'b1, 1'b1);
        cycles(64);
        expect_b("par_good", 11'h03C);

        // Second stop bit low: framing error, data intact, no spurious frame
        send_b(8'h55, 1'b0, 1'b1, 1'b0);
        cycles(64);
        expect_b("stop2_low", 11'h155);
        check_value("stop2_single", 32'(q_b.size()), 32'd0);
        check_value("stop2_idle", 32'(busy_b), 32'd0);

        // Break: line low 12 bit times, then high
        drive(1'b1, 1'b0);
        cycles(12 * 32);
        drive(1'b1, 1'b1);
        cycles(20);
        check_value("brk_busy_hold", 32'(busy_b), 32'd1);
        cycles(25);
        check_value("brk_busy_drop", 32'(busy_b), 32'd0);
        cycles(64);
        expect_b("brk_entry", 11'h500);
        check_value("brk_single", 32'(q_b.size()), 32'd0);
        check_value("brk_no_ovr", 32'(ovr_cnt_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
